// File: rtl/keypad_event_encoder.sv
// rtl/keypad_event_encoder.sv - debounced keypad event encoder with event FIFO
//
// Purpose: samples an active-low key bitmap on the en strobe, tracks each press
// through IDLE/PUSH/OUT, encodes the single pressed key on release and queues the
// code in a show-ahead FIFO drained by a valid/ready handshake. A legacy key_trick
// pulse is retriggered on every enqueue attempt.
// Optional feature: define KEY_REPEAT_EN to enable hold-to-repeat events.
//
// Ports:
//   clk_100M     in   system clock
//   rst_p        in   synchronous active-high reset
//   en           in   sample strobe for detect FSM, key_trick and repeat timers
//   key_num      in   key bitmap, bit i low = key i pressed
//   key_code     out  code at FIFO head (last head value while empty)
//   key_valid    out  FIFO not empty
//   key_ready    in   consumer accepts head when key_valid & key_ready
//   key_trick    out  high PULSE_LEN en-cycles after each enqueue attempt
//   key_abnormal out  one-cycle pulse when a multi-key press is discarded
//   fifo_level   out  entries held
//   overflow     out  sticky, set when an event is dropped on a full FIFO
module keypad_event_encoder #(
    parameter int KEY_NUM    = 16,
    parameter int CODE_W     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int PULSE_LEN  = 62,
    parameter int REPEAT_DLY = 50,
    parameter int REPEAT_PER = 10
) (
    input  logic                            clk_100M,
    input  logic                            rst_p,
    input  logic                            en,
    input  logic [KEY_NUM-1:0]              key_num,
    output logic [CODE_W-1:0]               key_code,
    output logic                            key_valid,
    input  logic                            key_ready,
    output logic                            key_trick,
    output logic                            key_abnormal,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overflow
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = AW + 1;

    if (KEY_NUM < 2 || KEY_NUM > 64 || KEY_NUM > (1 << CODE_W) ||
        FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        PULSE_LEN < 1 || PULSE_LEN > 255 ||
        REPEAT_PER < 1 || REPEAT_DLY < REPEAT_PER) begin : g_bad_params
        $error("keypad_event_encoder: illegal parameter set");
    end

    typedef enum logic [1:0] {S_IDLE, S_PUSH, S_OUT} state_e;

    state_e              state_q;
    logic                push_q;
    logic                abn_q;
    logic [CODE_W-1:0]   idx_q;
    logic                abnormal_q;

    // Key sample decode: a set bit in low_d is a pressed key.
    logic [KEY_NUM-1:0]  low_d;
    logic                multi_d;
    logic                single_d;
    logic [CODE_W-1:0]   idx_d;

    always_comb begin
        low_d    = ~key_num;
        multi_d  = |(low_d & (low_d - KEY_NUM'(1)));
        single_d = (|low_d) && !multi_d;
        idx_d    = '0;
        for (int i = 0; i < KEY_NUM; i++) begin
            if (low_d[i]) idx_d = CODE_W'(i);
        end
    end

    logic enq_release;
    logic enq;
    assign enq_release = (state_q == S_OUT) && en && !abn_q;

`ifdef KEY_REPEAT_EN
    logic        have_key_q;
    logic [15:0] hold_q;
    logic        rep_fire;

    // A same-cycle abnormal sample suppresses the repeat as well.
    assign rep_fire = en && (state_q == S_PUSH) && have_key_q && !abn_q && !multi_d &&
                      (hold_q == 16'(REPEAT_DLY - 1));
    assign enq      = enq_release | rep_fire;

    // After a repeat, rewind so the next one lands REPEAT_PER en-cycles later.
    always_ff @(posedge clk_100M) begin
        if (rst_p || state_q != S_PUSH) begin
            hold_q <= '0;
        end else if (en && have_key_q && !abn_q) begin
            if (rep_fire) hold_q <= 16'(REPEAT_DLY - REPEAT_PER);
            else          hold_q <= hold_q + 16'd1;
        end
    end
`else
    assign enq = enq_release;
`endif

    always_ff @(posedge clk_100M) begin
        if (rst_p) begin
            state_q    <= S_IDLE;
            push_q     <= 1'b0;
            abn_q      <= 1'b0;
            idx_q      <= '0;
            abnormal_q <= 1'b0;
`ifdef KEY_REPEAT_EN
            have_key_q <= 1'b0;
`endif
        end else begin
            abnormal_q <= 1'b0;
            if (en) begin
                push_q <= (key_num != '1);
                case (state_q)
                    S_IDLE: begin
                        if (push_q) begin
                            state_q <= S_PUSH;
                            abn_q   <= 1'b0;
`ifdef KEY_REPEAT_EN
                            have_key_q <= 1'b0;
`endif
                        end
                    end
                    S_PUSH: begin
                        if (multi_d) begin
                            abn_q <= 1'b1;
                        end else if (single_d) begin
                            idx_q <= idx_d;
`ifdef KEY_REPEAT_EN
                            have_key_q <= 1'b1;
`endif
                        end
                        if (!push_q) state_q <= S_OUT;
                    end
                    S_OUT: begin
                        state_q    <= S_IDLE;
                        abnormal_q <= abn_q;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // Event FIFO, show-ahead.
    logic [CODE_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [LVL_W-1:0]  level_q;
    logic [CODE_W-1:0] last_q;
    logic              overflow_q;
    logic [7:0]        trick_q;
    logic              full;
    logic              pop;
    logic              wr;

    assign key_valid = (level_q != '0);
    assign full      = (level_q == LVL_W'(FIFO_DEPTH));
    assign pop       = key_valid && key_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr        = enq && (!full || pop);

    always_ff @(posedge clk_100M) begin
        if (wr) mem_q[wr_ptr_q] <= idx_q;
    end

    always_ff @(posedge clk_100M) begin
        if (rst_p) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            last_q     <= '0;
            overflow_q <= 1'b0;
            trick_q    <= '0;
        end else begin
            if (wr)  wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (wr && !pop)      level_q <= level_q + LVL_W'(1);
            else if (!wr && pop) level_q <= level_q - LVL_W'(1);
            if (key_valid) last_q <= mem_q[rd_ptr_q];
            if (enq && !wr) overflow_q <= 1'b1;
            if (enq)                       trick_q <= 8'(PULSE_LEN);
            else if (en && trick_q != '0)  trick_q <= trick_q - 8'd1;
        end
    end

    assign key_code     = key_valid ? mem_q[rd_ptr_q] : last_q;
    assign key_trick    = (trick_q != '0);
    assign key_abnormal = abnormal_q;
    assign fifo_level   = level_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_keypad_event_encoder.sv
// tb/tb_keypad_event_encoder.sv - directed self-checking bench for keypad_event_encoder
module tb_keypad_event_encoder;

    logic        clk = 1'b0;
    logic        rst_p;
    logic        en;
    logic [15:0] key_num;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready;
    logic        key_trick;
    logic        key_abnormal;
    logic [2:0]  fifo_level;
    logic        overflow;

    logic [31:0] key_num32;
    logic [4:0]  key_code32;
    logic        key_valid32;
    logic        key_trick32;
    logic        key_abnormal32;
    logic [2:0]  fifo_level32;
    logic        overflow32;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    keypad_event_encoder dut (
        .clk_100M(clk), .rst_p(rst_p), .en(en), .key_num(key_num),
        .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
        .key_trick(key_trick), .key_abnormal(key_abnormal),
        .fifo_level(fifo_level), .overflow(overflow)
    );

    keypad_event_encoder #(.KEY_NUM(32), .CODE_W(5)) dut32 (
        .clk_100M(clk), .rst_p(rst_p), .en(en), .key_num(key_num32),
        .key_code(key_code32), .key_valid(key_valid32), .key_ready(1'b0),
        .key_trick(key_trick32), .key_abnormal(key_abnormal32),
        .fifo_level(fifo_level32), .overflow(overflow32)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_p = 1'b1;
        step();
        step();
        rst_p = 1'b0;
    endtask

    // Hold a key for 'hold' en-cycles, release, and wait for the enqueue edge.
    task automatic press(input logic [15:0] k, input int hold);
        key_num = k;
        repeat (hold) step();
        key_num = 16'hFFFF;
        repeat (3) step();
    endtask

    initial begin
        int cnt;
        rst_p     = 1'b0;
        en        = 1'b1;
        key_num   = 16'hFFFF;
        key_num32 = 32'hFFFF_FFFF;
        key_ready = 1'b0;
        do_reset();

        check("rst_valid", key_valid, 0);
        check("rst_code", key_code, 0);
        check("rst_trick", key_trick, 0);
        check("rst_abn", key_abnormal, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ovf", overflow, 0);

        // 1: single press, consumer ready, trick length
        key_ready = 1'b1;
        key_num   = 16'hFFFE;
        repeat (5) step();
        key_num = 16'hFFFF;
        repeat (2) step();
        check("t1_latency_not_yet", key_valid, 0);
        step();
        check("t1_valid", key_valid, 1);
        check("t1_code", key_code, 0);
        check("t1_level", fifo_level, 1);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (key_trick) cnt++;
            step();
        end
        check("t1_trick_len", cnt, 62);
        check("t1_popped", key_valid, 0);
        key_ready = 1'b0;

        // 2: fill past depth with key 10
        for (int p = 0; p < 4; p++) press(16'hFBFF, 4);
        check("t2_level4", fifo_level, 4);
        check("t2_ovf_before", overflow, 0);
        press(16'hFBFF, 4);
        check("t2_level_after5", fifo_level, 4);
        check("t2_ovf_after5", overflow, 1);
        check("t2_trick", key_trick, 1);
        key_ready = 1'b1;
        for (int p = 0; p < 4; p++) begin
            check("t2_pop_valid", key_valid, 1);
            check("t2_pop_code", key_code, 4'hA);
            step();
        end
        key_ready = 1'b0;
        check("t2_empty", key_valid, 0);
        check("t2_ovf_sticky", overflow, 1);
        check("t2_code_hold", key_code, 4'hA);

        // 3: second key during PUSH -> abnormal
        do_reset();
        key_num = 16'hFFFE;
        repeat (3) step();
        key_num = 16'hFFFC;
        step();
        key_num = 16'hFFFF;
        repeat (2) step();
        check("t3_abn_early", key_abnormal, 0);
        step();
        check("t3_abn_pulse", key_abnormal, 1);
        check("t3_level", fifo_level, 0);
        check("t3_trick", key_trick, 0);
        step();
        check("t3_abn_one_cycle", key_abnormal, 0);
        check("t3_valid", key_valid, 0);

        // 4: full FIFO, push and pop on the same edge
        do_reset();
        press(16'hFFFD, 4);
        press(16'hFFFB, 4);
        press(16'hFFF7, 4);
        press(16'hFFEF, 4);
        check("t4_level_full", fifo_level, 4);
        key_num = 16'hFF7F;
        repeat (4) step();
        key_num = 16'hFFFF;
        repeat (2) step();
        key_ready = 1'b1;
        step();
        key_ready = 1'b0;
        check("t4_level_same", fifo_level, 4);
        check("t4_ovf", overflow, 0);
        check("t4_head", key_code, 2);
        key_ready = 1'b1;
        check("t4_code_a", key_code, 2);
        step();
        check("t4_code_b", key_code, 3);
        step();
        check("t4_code_c", key_code, 4);
        step();
        check("t4_tail", key_code, 7);
        step();
        check("t4_empty", key_valid, 0);
        key_ready = 1'b0;

        // 5: 32-key instance, bit 17
        key_num32 = ~(32'h1 << 17);
        repeat (4) step();
        key_num32 = 32'hFFFF_FFFF;
        repeat (3) step();
        check("t5_valid32", key_valid32, 1);
        check("t5_code32", key_code32, 5'd17);

        // en gaps freeze FSM and trick
        do_reset();
        press(16'hFFEF, 5);
        check("gap_code", key_code, 4);
        check("gap_trick", key_trick, 1);
        en = 1'b0;
        key_num = 16'hFFDF;
        repeat (100) step();
        check("gap_trick_frozen", key_trick, 1);
        check("gap_no_press", fifo_level, 1);
        key_num = 16'hFFFF;
        en = 1'b1;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (key_trick) cnt++;
            step();
        end
        check("gap_trick_len", cnt, 62);
        check("gap_level", fifo_level, 1);

        // 6: long hold
        do_reset();
        press(16'h7FFF, 75);
`ifdef KEY_REPEAT_EN
        check("t6_level_rep", fifo_level, 4);
`else
        check("t6_level_norep", fifo_level, 1);
`endif
        check("t6_code", key_code, 4'hF);
`ifdef KEY_REPEAT_EN
        do_reset();
        key_num = 16'h7FFF;
        for (int i = 0; i < 75; i++) begin
            en = 1'b1;
            step();
            en = 1'b0;
            step();
            step();
        end
        en = 1'b1;
        key_num = 16'hFFFF;
        repeat (3) step();
        check("t6_gap_level", fifo_level, 4);
`endif

        // reset mid-press, key still held re-enters PUSH
        do_reset();
        key_num = 16'hFFFD;
        repeat (55) step();
`ifdef KEY_REPEAT_EN
        check("mid_pre_level", fifo_level, 1);
`else
        check("mid_pre_level", fifo_level, 0);
`endif
        rst_p = 1'b1;
        step();
        rst_p = 1'b0;
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_valid", key_valid, 0);
        press(16'hFFFD, 5);
        check("mid_re_level", fifo_level, 1);
        check("mid_re_code", key_code, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
